// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: states, NPC/ALU selects,
// opcode/funct constants and the decoded instruction record. MDU state under MC_CTRL_MDU_EN.
package mc_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
`ifdef MC_CTRL_MDU_EN
        , S_MDU  = 3'd5
`endif
    } state_e;

    localparam logic [2:0] NPC_PC4 = 3'd0;
    localparam logic [2:0] NPC_BEQ = 3'd1;
    localparam logic [2:0] NPC_J   = 3'd2;
    localparam logic [2:0] NPC_JR  = 3'd4;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_OR  = 4'd2;
    localparam logic [3:0] ALU_LUI = 4'd3;
    localparam logic [3:0] ALU_SLL = 4'd4;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    localparam logic [2:0] MDU_MULT  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd1;
    localparam logic [2:0] MDU_DIV   = 3'd2;
    localparam logic [2:0] MDU_DIVU  = 3'd3;
    localparam logic [2:0] MDU_MFHI  = 3'd4;
    localparam logic [2:0] MDU_MFLO  = 3'd5;
    localparam logic [2:0] MDU_MTHI  = 3'd6;
    localparam logic [2:0] MDU_MTLO  = 3'd7;

    typedef enum logic [3:0] {
        CLS_ALU,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_JUMP,
        CLS_JAL,
        CLS_JR,
        CLS_MDU,
        CLS_MF,
        CLS_MT,
        CLS_UNKNOWN
    } iclass_e;

    typedef struct packed {
        iclass_e    cls;
        logic [3:0] alu_op;
        logic       b_sel;
        logic       ext_op;
        logic [1:0] wr_sel;
        logic [1:0] rfwd_sel;
        logic [2:0] mdu_op;
    } dec_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction-class decoder; MDU funct codes decode only under MC_CTRL_MDU_EN.
module mc_decode
    import mc_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output dec_t       dec
);

    always_comb begin
        dec          = '0;
        dec.cls      = CLS_UNKNOWN;
        dec.alu_op   = ALU_ADD;
        unique case (opcode)
            OP_RTYPE: begin
                unique case (funct)
                    FN_ADDU: begin
                        dec.cls    = CLS_ALU;
                        dec.alu_op = ALU_ADD;
                        dec.wr_sel = 2'd1;
                    end
                    FN_SUBU: begin
                        dec.cls    = CLS_ALU;
                        dec.alu_op = ALU_SUB;
                        dec.wr_sel = 2'd1;
                    end
                    FN_SLL: begin
                        dec.cls    = CLS_ALU;
                        dec.alu_op = ALU_SLL;
                        dec.wr_sel = 2'd1;
                    end
                    FN_JR: dec.cls = CLS_JR;
`ifdef MC_CTRL_MDU_EN
                    FN_MULT:  begin dec.cls = CLS_MDU; dec.mdu_op = MDU_MULT;  end
                    FN_MULTU: begin dec.cls = CLS_MDU; dec.mdu_op = MDU_MULTU; end
                    FN_DIV:   begin dec.cls = CLS_MDU; dec.mdu_op = MDU_DIV;   end
                    FN_DIVU:  begin dec.cls = CLS_MDU; dec.mdu_op = MDU_DIVU;  end
                    FN_MFHI, FN_MFLO: begin
                        dec.cls      = CLS_MF;
                        dec.mdu_op   = (funct == FN_MFHI) ? MDU_MFHI : MDU_MFLO;
                        dec.wr_sel   = 2'd1;
                        dec.rfwd_sel = 2'd3;
                    end
                    FN_MTHI, FN_MTLO: begin
                        dec.cls    = CLS_MT;
                        dec.mdu_op = (funct == FN_MTHI) ? MDU_MTHI : MDU_MTLO;
                    end
`endif
                    default: dec.cls = CLS_UNKNOWN;
                endcase
            end
            OP_ORI: begin
                dec.cls    = CLS_ALU;
                dec.alu_op = ALU_OR;
                dec.b_sel  = 1'b1;
            end
            OP_LUI: begin
                dec.cls    = CLS_ALU;
                dec.alu_op = ALU_LUI;
                dec.b_sel  = 1'b1;
            end
            OP_LW: begin
                dec.cls      = CLS_LOAD;
                dec.b_sel    = 1'b1;
                dec.ext_op   = 1'b1;
                dec.rfwd_sel = 2'd1;
            end
            OP_SW: begin
                dec.cls    = CLS_STORE;
                dec.b_sel  = 1'b1;
                dec.ext_op = 1'b1;
            end
            OP_BEQ: begin
                dec.cls    = CLS_BRANCH;
                dec.alu_op = ALU_SUB;
            end
            OP_J: dec.cls = CLS_JUMP;
            OP_JAL: begin
                dec.cls      = CLS_JAL;
                dec.wr_sel   = 2'd2;
                dec.rfwd_sel = 2'd2;
            end
            default: dec.cls = CLS_UNKNOWN;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS main controller: FETCH/DECODE/EXEC/MEM/WB sequencer with retire counter.
// MC_CTRL_MDU_EN adds the S_MDU state and the mdu_start/mdu_op/mdu_busy handshake.
module mc_ctrl
    import mc_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        zero,
    input  logic        im_ready,
    input  logic        dm_ready,
`ifdef MC_CTRL_MDU_EN
    output logic        mdu_start,
    output logic [2:0]  mdu_op,
    input  logic        mdu_busy,
`endif
    output logic        ir_we,
    output logic        pc_we,
    output logic [2:0]  npc_op,
    output logic        rf_we,
    output logic [1:0]  wr_sel,
    output logic [1:0]  rfwd_sel,
    output logic [3:0]  alu_op,
    output logic        b_sel,
    output logic        ext_op,
    output logic        dm_we,
    output logic [2:0]  dm_op,
    output logic [2:0]  state,
    output logic [31:0] retired
);

    state_e      state_q, state_d;
    logic [31:0] retired_q;
    dec_t        dec;
    logic        ir_we_c, pc_we_c, rf_we_c, dm_we_c, mdu_start_c;

    mc_decode u_decode (
        .opcode (opcode),
        .funct  (funct),
        .dec    (dec)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            retired_q <= 32'd0;
        end else begin
            state_q <= state_d;
            if (pc_we_c) begin
                retired_q <= retired_q + 32'd1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ir_we_c     = 1'b0;
        pc_we_c     = 1'b0;
        rf_we_c     = 1'b0;
        dm_we_c     = 1'b0;
        mdu_start_c = 1'b0;
        npc_op      = NPC_PC4;
        unique case (state_q)
            S_FETCH: begin
                ir_we_c = im_ready;
                if (im_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                unique case (dec.cls)
                    CLS_JUMP, CLS_JR, CLS_UNKNOWN: begin
                        pc_we_c = 1'b1;
                        npc_op  = (dec.cls == CLS_JUMP) ? NPC_J :
                                  (dec.cls == CLS_JR)   ? NPC_JR : NPC_PC4;
                        state_d = S_FETCH;
                    end
                    CLS_JAL: state_d = S_WB;
                    default: state_d = S_EXEC;
                endcase
            end
            S_EXEC: begin
                unique case (dec.cls)
                    CLS_ALU:              state_d = S_WB;
                    CLS_LOAD, CLS_STORE:  state_d = S_MEM;
                    CLS_BRANCH: begin
                        pc_we_c = 1'b1;
                        npc_op  = NPC_BEQ;
                        state_d = S_FETCH;
                    end
`ifdef MC_CTRL_MDU_EN
                    CLS_MDU: begin
                        mdu_start_c = 1'b1;
                        state_d     = S_MDU;
                    end
                    CLS_MF: begin
                        if (!mdu_busy) state_d = S_WB;
                    end
                    CLS_MT: begin
                        mdu_start_c = 1'b1;
                        pc_we_c     = 1'b1;
                        state_d     = S_FETCH;
                    end
`endif
                    // Not reachable from DECODE; retire as a nop so the FSM cannot wedge.
                    default: begin
                        pc_we_c = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEM: begin
                dm_we_c = (dec.cls == CLS_STORE);
                if (dm_ready) begin
                    if (dec.cls == CLS_STORE) begin
                        pc_we_c = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                rf_we_c = 1'b1;
                pc_we_c = 1'b1;
                npc_op  = (dec.cls == CLS_JAL) ? NPC_J : NPC_PC4;
                state_d = S_FETCH;
            end
`ifdef MC_CTRL_MDU_EN
            S_MDU: begin
                if (!mdu_busy) begin
                    pc_we_c = 1'b1;
                    state_d = S_FETCH;
                end
            end
`endif
            default: state_d = S_FETCH;
        endcase
        // Reset cycle: nothing may be committed whatever state is current.
        if (!reset) begin
            ir_we_c     = 1'b0;
            pc_we_c     = 1'b0;
            rf_we_c     = 1'b0;
            dm_we_c     = 1'b0;
            mdu_start_c = 1'b0;
        end
    end

    assign ir_we    = ir_we_c;
    assign pc_we    = pc_we_c;
    assign rf_we    = rf_we_c;
    assign dm_we    = dm_we_c;
    assign wr_sel   = dec.wr_sel;
    assign rfwd_sel = dec.rfwd_sel;
    assign alu_op   = dec.alu_op;
    assign b_sel    = dec.b_sel;
    assign ext_op   = dec.ext_op;
    assign dm_op    = 3'd0;
    assign state    = state_q;
    assign retired  = retired_q;

`ifdef MC_CTRL_MDU_EN
    assign mdu_start = mdu_start_c;
    assign mdu_op    = dec.mdu_op;
    logic unused_sig;
    assign unused_sig = zero;
`else
    logic unused_sig;
    assign unused_sig = ^{zero, dec.mdu_op, mdu_start_c};
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: per-cycle expected traces built from instruction-class rules.
module tb_mc_ctrl;

    logic        clk = 1'b0;
    logic        reset, zero, im_ready, dm_ready;
    logic [5:0]  opcode, funct;
    logic        ir_we, pc_we, rf_we, b_sel, ext_op, dm_we;
    logic [2:0]  npc_op, dm_op, state;
    logic [1:0]  wr_sel, rfwd_sel;
    logic [3:0]  alu_op;
    logic [31:0] retired;
`ifdef MC_CTRL_MDU_EN
    logic        mdu_start, mdu_busy;
    logic [2:0]  mdu_op;
`endif

    always #5 clk = ~clk;

    mc_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .opcode   (opcode),
        .funct    (funct),
        .zero     (zero),
        .im_ready (im_ready),
        .dm_ready (dm_ready),
`ifdef MC_CTRL_MDU_EN
        .mdu_start(mdu_start),
        .mdu_op   (mdu_op),
        .mdu_busy (mdu_busy),
`endif
        .ir_we    (ir_we),
        .pc_we    (pc_we),
        .npc_op   (npc_op),
        .rf_we    (rf_we),
        .wr_sel   (wr_sel),
        .rfwd_sel (rfwd_sel),
        .alu_op   (alu_op),
        .b_sel    (b_sel),
        .ext_op   (ext_op),
        .dm_we    (dm_we),
        .dm_op    (dm_op),
        .state    (state),
        .retired  (retired)
    );

    localparam int C_ALU = 0, C_LW = 1, C_SW = 2, C_BEQ = 3, C_J = 4, C_JAL = 5, C_JR = 6;
    localparam int C_UNK = 7;

    typedef struct {
        logic [5:0] opc;
        logic [5:0] fn;
        int cls, alu, bsel, ext, wr, rfwd;
    } ins_t;

    typedef struct {
        bit im, dm, ir, pc, rf, dmw;
        int st, npc, wr, rfwd, alu, bsel, ext;
    } cyc_t;

    ins_t tbl [13];
    cyc_t exp_q [$];
    int   checks = 0;
    int   errors = 0;
    int   model_retired = 0;
    int   zero_force = -1;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic cyc_t blank(int st);
        cyc_t c;
        c.st = st; c.im = 1'($urandom); c.dm = 1'($urandom);
        c.ir = 0; c.pc = 0; c.rf = 0; c.dmw = 0;
        c.npc = -1; c.wr = -1; c.rfwd = -1; c.alu = -1; c.bsel = -1; c.ext = -1;
        return c;
    endfunction

    function automatic void with_alu(ref cyc_t c, input ins_t e);
        c.alu = e.alu; c.bsel = e.bsel; c.ext = e.ext;
    endfunction

    // Expected cycle-by-cycle trace of one instruction from its class and ready waits.
    function automatic void build(int k, int imw, int dmw);
        ins_t e = tbl[k];
        cyc_t c;
        for (int i = 0; i <= imw; i++) begin
            c = blank(0); c.im = (i == imw); c.ir = (i == imw);
            exp_q.push_back(c);
        end
        c = blank(1);
        if (e.cls == C_J || e.cls == C_JR || e.cls == C_UNK) begin
            c.pc = 1; c.npc = (e.cls == C_J) ? 2 : (e.cls == C_JR) ? 4 : 0;
            exp_q.push_back(c);
            return;
        end
        exp_q.push_back(c);
        if (e.cls != C_JAL) begin
            c = blank(2); with_alu(c, e);
            if (e.cls == C_BEQ) begin
                c.pc = 1; c.npc = 1;
                exp_q.push_back(c);
                return;
            end
            exp_q.push_back(c);
            if (e.cls == C_LW || e.cls == C_SW) begin
                for (int i = 0; i <= dmw; i++) begin
                    c = blank(3); with_alu(c, e);
                    c.dm = (i == dmw); c.dmw = (e.cls == C_SW);
                    if (i == dmw && e.cls == C_SW) begin c.pc = 1; c.npc = 0; end
                    exp_q.push_back(c);
                end
                if (e.cls == C_SW) return;
            end
        end
        c = blank(4);
        c.rf = 1; c.pc = 1; c.npc = (e.cls == C_JAL) ? 2 : 0;
        c.wr = e.wr; c.rfwd = e.rfwd;
        if (e.cls != C_JAL) with_alu(c, e);
        exp_q.push_back(c);
    endfunction

    // Called at posedge+1: drive, sample at negedge, return at next posedge+1.
    task automatic cycle_check(cyc_t c);
        im_ready = c.im; dm_ready = c.dm;
        zero = (zero_force >= 0) ? 1'(zero_force) : 1'($urandom);
        @(negedge clk);
        check("state", 32'(state), 32'(c.st));
        check("ir_we", 32'(ir_we), 32'(c.ir));
        check("pc_we", 32'(pc_we), 32'(c.pc));
        check("rf_we", 32'(rf_we), 32'(c.rf));
        check("dm_we", 32'(dm_we), 32'(c.dmw));
        check("dm_op", 32'(dm_op), 32'd0);
        check("retired", retired, 32'(model_retired));
        if (c.npc >= 0)  check("npc_op", 32'(npc_op), 32'(c.npc));
        if (c.wr >= 0)   check("wr_sel", 32'(wr_sel), 32'(c.wr));
        if (c.rfwd >= 0) check("rfwd_sel", 32'(rfwd_sel), 32'(c.rfwd));
        if (c.alu >= 0)  check("alu_op", 32'(alu_op), 32'(c.alu));
        if (c.bsel >= 0) check("b_sel", 32'(b_sel), 32'(c.bsel));
        if (c.ext >= 0)  check("ext_op", 32'(ext_op), 32'(c.ext));
`ifdef MC_CTRL_MDU_EN
        check("mdu_start", 32'(mdu_start), 32'd0);
`endif
        @(posedge clk); #1;
        if (c.pc) model_retired++;
    endtask

    task automatic run_instr(int k, int imw, int dmw);
        opcode = tbl[k].opc;
        funct  = (tbl[k].opc == 6'h00) ? tbl[k].fn : 6'($urandom);
        build(k, imw, dmw);
        while (exp_q.size() > 0) cycle_check(exp_q.pop_front());
    endtask

    task automatic reset_mid_sw();
        opcode = 6'h2B; funct = 6'($urandom);
        build(6, 0, 5);
        for (int i = 0; i < 4; i++) cycle_check(exp_q.pop_front());
        exp_q.delete();
        reset = 1'b0; dm_ready = 1'b0; im_ready = 1'b1;
        @(negedge clk);
        check("rst_state_pre", 32'(state), 32'd3);
        check("rst_dm_we0", 32'(dm_we), 32'd0);
        check("rst_pc_we0", 32'(pc_we), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_state", 32'(state), 32'd0);
        check("rst_retired", retired, 32'd0);
        check("rst_dm_we1", 32'(dm_we), 32'd0);
        check("rst_ir_we1", 32'(ir_we), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        model_retired = 0;
    endtask

`ifdef MC_CTRL_MDU_EN
    task automatic mdu_test();
        int mdu_cycles = 0, starts = 0;
        bit done = 0;
        opcode = 6'h00; funct = 6'h18; im_ready = 1; dm_ready = 1; mdu_busy = 0;
        @(negedge clk); check("mdu_fetch", 32'(state), 32'd0);
        @(posedge clk); #1;
        @(negedge clk); check("mdu_decode", 32'(state), 32'd1);
        @(posedge clk); #1;
        mdu_busy = 1;
        @(negedge clk);
        check("mdu_exec", 32'(state), 32'd2);
        check("mdu_start_exec", 32'(mdu_start), 32'd1);
        @(posedge clk); #1;
        for (int i = 0; i < 20 && !done; i++) begin
            mdu_busy = (i < 4);
            @(negedge clk);
            if (state == 3'd5) mdu_cycles++;
            if (mdu_start) starts++;
            if (pc_we) done = 1;
            @(posedge clk); #1;
        end
        mdu_busy = 0;
        model_retired++;
        check("mdu_done", 32'(done), 32'd1);
        check("mdu_cycles", 32'(mdu_cycles), 32'd5);
        check("mdu_extra_starts", 32'(starts), 32'd0);
        check("mdu_retired", retired, 32'(model_retired));
    endtask
`endif

    initial begin
        tbl = '{
            '{6'h00, 6'h21, C_ALU, 0, 0, -1, 1, 0},
            '{6'h00, 6'h23, C_ALU, 1, 0, -1, 1, 0},
            '{6'h00, 6'h00, C_ALU, 4, 0, -1, 1, 0},
            '{6'h0D, 6'h00, C_ALU, 2, 1, 0, 0, 0},
            '{6'h0F, 6'h00, C_ALU, 3, 1, -1, 0, 0},
            '{6'h23, 6'h00, C_LW, 0, 1, 1, 0, 1},
            '{6'h2B, 6'h00, C_SW, 0, 1, 1, -1, -1},
            '{6'h04, 6'h00, C_BEQ, 1, 0, -1, -1, -1},
            '{6'h02, 6'h00, C_J, -1, -1, -1, -1, -1},
            '{6'h03, 6'h00, C_JAL, -1, -1, -1, 2, 2},
            '{6'h00, 6'h08, C_JR, -1, -1, -1, -1, -1},
            '{6'h3F, 6'h00, C_UNK, -1, -1, -1, -1, -1},
            '{6'h00, 6'h2A, C_UNK, -1, -1, -1, -1, -1}
        };
        reset = 1'b0; zero = 0; im_ready = 1; dm_ready = 1; opcode = 6'h00; funct = 6'h21;
`ifdef MC_CTRL_MDU_EN
        mdu_busy = 0;
`endif
        @(posedge clk);
        @(negedge clk);
        check("init_state", 32'(state), 32'd0);
        check("init_retired", retired, 32'd0);
        check("init_ir_we", 32'(ir_we), 32'd0);
        check("init_pc_we", 32'(pc_we), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;

        run_instr(5, 0, 0);                    // lw, ready high
        zero_force = 1; run_instr(7, 0, 0);
        zero_force = 0; run_instr(7, 0, 0);
        zero_force = -1;
        run_instr(9, 0, 0);                    // jal
        run_instr(6, 0, 3);                    // sw with dm_ready low 3 cycles
        run_instr(11, 0, 0);                   // opcode 0x3F
        run_instr(8, 2, 0);
        run_instr(10, 1, 0);
        for (int n = 0; n < 200; n++) begin
            run_instr(int'($urandom_range(0, 12)), int'($urandom_range(0, 2)),
                      int'($urandom_range(0, 3)));
        end
        reset_mid_sw();
        run_instr(0, 0, 0);
        run_instr(5, 1, 2);
`ifdef MC_CTRL_MDU_EN
        mdu_test();
        run_instr(3, 0, 0);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
